// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the memory port arbiter.
// The response-tracking struct is sized from the package defaults.
// Keep the top-level parameter overrides in step with these values.
package mem_port_arbiter_pkg;

  localparam int MEM_ARB_N_PORTS    = 2;
  localparam int MEM_ARB_RESP_DEPTH = 4;
  localparam int MEM_ARB_RLEN_W     = 5;
  localparam int MEM_ARB_ID_W       = (MEM_ARB_N_PORTS > 1) ? $clog2(MEM_ARB_N_PORTS) : 1;

  // The arbiter is either free to pick a port or held on the port it already granted.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // One in-flight read burst: who asked for it and how many beats remain after the first.
  typedef struct packed {
    logic [MEM_ARB_ID_W-1:0]   id;
    logic [MEM_ARB_RLEN_W-1:0] rlen;
  } mem_arb_resp_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the external memory port.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_PORTS = MEM_ARB_N_PORTS,
  parameter int RLEN_W  = MEM_ARB_RLEN_W
);

  // Requester side
  logic [N_PORTS-1:0]             req_request;
  logic [N_PORTS-1:0][29:0]       req_addr;
  logic [N_PORTS-1:0]             req_rnw;
  logic [N_PORTS-1:0][RLEN_W-1:0] req_rlen;
  logic [N_PORTS-1:0][31:0]       req_wdata;
  logic [N_PORTS-1:0][3:0]        req_wbe;
  logic [N_PORTS-1:0]             req_ack;
  logic [N_PORTS-1:0]             req_rvalid;
  logic [31:0]                    req_rdata;

  // Memory side
  logic                           mem_request;
  logic [29:0]                    mem_addr;
  logic                           mem_rnw;
  logic [RLEN_W-1:0]              mem_rlen;
  logic [31:0]                    mem_wdata;
  logic [3:0]                     mem_wbe;
  logic                           mem_ack;
  logic                           mem_rvalid;
  logic [31:0]                    mem_rdata;
  logic                           write_outstanding;
  logic [N_PORTS-1:0]             port_write_outstanding;

  modport slave (
    input  req_request, req_addr, req_rnw, req_rlen, req_wdata, req_wbe,
    output req_ack, req_rvalid, req_rdata,
    output mem_request, mem_addr, mem_rnw, mem_rlen, mem_wdata, mem_wbe,
    input  mem_ack, mem_rvalid, mem_rdata, write_outstanding,
    output port_write_outstanding
  );

  modport master (
    output req_request, req_addr, req_rnw, req_rlen, req_wdata, req_wbe,
    input  req_ack, req_rvalid, req_rdata,
    input  mem_request, mem_addr, mem_rnw, mem_rlen, mem_wdata, mem_wbe,
    output mem_ack, mem_rvalid, mem_rdata, write_outstanding,
    input  port_write_outstanding
  );

endinterface

// File: rtl/mem_port_arbiter_fifo.sv
// Small synchronous FIFO holding the outstanding read bursts in issue order.
// A push and a pop in the same cycle are both honoured, including when full.
module mem_port_arbiter_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  // Storage write.
  // NOTE: the data array has no reset; the pointers and count define which entries are valid,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_out = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between N requesters.
// A grant that is not accepted immediately is held until mem_ack; read bursts are
// queued in issue order so returning beats are steered to the port that asked.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_PORTS    = MEM_ARB_N_PORTS,
  parameter int RESP_DEPTH = MEM_ARB_RESP_DEPTH,
  parameter int RLEN_W     = MEM_ARB_RLEN_W
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef logic [MEM_ARB_ID_W-1:0] id_t;

  arb_state_e         state;
  arb_state_e         state_next;
  id_t                lock_id;
  id_t                lock_id_next;
  id_t                prio_ptr;
  logic [N_PORTS-1:0] eligible;
  logic               pick_valid;
  id_t                pick_id;
  logic               gnt_valid;
  id_t                gnt_id;
  logic               accept;
  logic [N_PORTS-1:0] wr_set;
  logic [N_PORTS-1:0] wr_flag;

  logic               resp_push;
  logic               resp_pop;
  logic               resp_empty;
  logic               resp_full;
  mem_arb_resp_t      resp_in;
  mem_arb_resp_t      resp_head;
  logic [RLEN_W-1:0]  beat_cnt;
  logic               beat_ok;
  logic               last_beat;

  // A read can only be granted while the response queue has room; writes always can.
  // The queue's full flag is registered, so a pop this cycle does not help a read this cycle.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      eligible[p] = bus.req_request[p] & (~bus.req_rnw[p] | ~resp_full);
    end
  end

  // Round-robin priority encoder: first eligible port at or after prio_ptr.
  always_comb begin
    id_t cand;
    // NOTE: every combinational output gets a default before any branch, otherwise a path
    // that skips the assignment infers a latch.
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = id_t'((int'(prio_ptr) + i) % N_PORTS);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Grant FSM: IDLE grants the encoder's choice; LOCKED holds the same port until accepted.
  always_comb begin
    state_next   = state;
    lock_id_next = lock_id;
    gnt_valid    = 1'b0;
    gnt_id       = pick_id;
    case (state)
      ARB_IDLE: begin
        gnt_valid = pick_valid;
        gnt_id    = pick_id;
        if (pick_valid && !bus.mem_ack) begin
          state_next   = ARB_LOCKED;
          lock_id_next = pick_id;
        end
      end
      ARB_LOCKED: begin
        gnt_valid = 1'b1;
        gnt_id    = lock_id;
        if (bus.mem_ack) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
    if (rst) gnt_valid = 1'b0;
  end

  // Drive the granted port's fields downstream and return the acknowledge to it.
  always_comb begin
    bus.mem_request = gnt_valid;
    bus.mem_addr    = bus.req_addr[gnt_id];
    bus.mem_rnw     = bus.req_rnw[gnt_id];
    bus.mem_rlen    = bus.req_rlen[gnt_id];
    bus.mem_wdata   = bus.req_wdata[gnt_id];
    bus.mem_wbe     = bus.req_wbe[gnt_id];
    accept          = gnt_valid & bus.mem_ack;
    bus.req_ack     = '0;
    if (accept) bus.req_ack[gnt_id] = 1'b1;
    wr_set = bus.mem_rnw ? '0 : bus.req_ack;
  end

  // State register, lock owner and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lock_id  <= '0;
      prio_ptr <= '0;
    end else begin
      state   <= state_next;
      lock_id <= lock_id_next;
      if (accept) prio_ptr <= (gnt_id == id_t'(N_PORTS - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Queue every accepted read; the head entry owns the beats currently returning.
  always_comb begin
    resp_in      = '0;
    resp_in.id   = gnt_id;
    resp_in.rlen = bus.req_rlen[gnt_id];
  end

  assign resp_push = accept & bus.mem_rnw;
  assign beat_ok   = bus.mem_rvalid & ~resp_empty & ~rst;
  assign last_beat = beat_ok && (beat_cnt == resp_head.rlen);
  assign resp_pop  = last_beat;

  mem_port_arbiter_fifo #(
    .DATA_W ($bits(mem_arb_resp_t)),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (resp_push),
    .pop      (resp_pop),
    .data_in  (resp_in),
    .data_out (resp_head),
    .empty    (resp_empty),
    .full     (resp_full)
  );

  // Steer each beat to the owner of the oldest outstanding burst.
  always_comb begin
    bus.req_rvalid = '0;
    if (beat_ok) bus.req_rvalid[resp_head.id] = 1'b1;
  end

  assign bus.req_rdata = bus.mem_rdata;

  // Count beats within the head burst; wrap to zero when its last beat arrives.
  always_ff @(posedge clk) begin
    if (rst)          beat_cnt <= '0;
    else if (beat_ok) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
  end

  // Remember which ports wrote since write_outstanding last dropped.
  always_ff @(posedge clk) begin
    if (rst) wr_flag <= '0;
    else     wr_flag <= wr_set | (wr_flag & {N_PORTS{bus.write_outstanding | (|wr_set)}});
  end

  assign bus.port_write_outstanding = wr_flag & {N_PORTS{bus.write_outstanding}};

  // A beat with no burst outstanding means the downstream side lost track of us.
  a_no_orphan_beat: assert property (@(posedge clk) disable iff (rst) !(bus.mem_rvalid && resp_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (two ports, four-deep response queue).
// Inputs change 2 time units after a rising edge; outputs are compared 1 unit later.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.N_PORTS(2), .RLEN_W(5)) bus ();

  mem_port_arbiter #(
    .N_PORTS    (2),
    .RESP_DEPTH (4),
    .RLEN_W     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.req_request       = '0;
    bus.req_addr          = '0;
    bus.req_rnw           = '0;
    bus.req_rlen          = '0;
    bus.req_wdata         = '0;
    bus.req_wbe           = '0;
    bus.mem_ack           = 1'b0;
    bus.mem_rvalid        = 1'b0;
    bus.mem_rdata         = '0;
    bus.write_outstanding = 1'b0;
  endtask

  task automatic set_port(input int p, input logic req, input logic [29:0] addr,
                          input logic rnw, input logic [4:0] rlen, input logic [31:0] wdata);
    bus.req_request[p] = req;
    bus.req_addr[p]    = addr;
    bus.req_rnw[p]     = rnw;
    bus.req_rlen[p]    = rlen;
    bus.req_wdata[p]   = wdata;
    bus.req_wbe[p]     = 4'hf;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_port(0, 1'b1, 30'h4, 1'b0, 5'd0, 32'h0);
    set_port(1, 1'b1, 30'h8, 1'b0, 5'd0, 32'h0);
    bus.mem_ack           = 1'b1;
    bus.write_outstanding = 1'b1;
    step();
    step();
    #1;
    total++; if (bus.mem_request !== 1'b0) begin bad++; $display("FAIL reset_mem_request: got %b want 0", bus.mem_request); end
    total++; if (bus.req_ack !== 2'b00) begin bad++; $display("FAIL reset_req_ack: got %b want 00", bus.req_ack); end
    total++; if (bus.req_rvalid !== 2'b00) begin bad++; $display("FAIL reset_req_rvalid: got %b want 00", bus.req_rvalid); end
    total++; if (bus.port_write_outstanding !== 2'b00) begin bad++; $display("FAIL reset_pwo: got %b want 00", bus.port_write_outstanding); end
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    logic [31:0] exp_d;
    set_port(1, 1'b1, 30'h100, 1'b1, 5'd7, 32'h0);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b10) begin bad++; $display("FAIL single_ack: got %b want 10", bus.req_ack); end
    total++; if (bus.mem_request !== 1'b1) begin bad++; $display("FAIL single_mem_request: got %b want 1", bus.mem_request); end
    total++; if (bus.mem_addr !== 30'h100) begin bad++; $display("FAIL single_mem_addr: got %h want 100", bus.mem_addr); end
    total++; if (bus.mem_rnw !== 1'b1 || bus.mem_rlen !== 5'd7) begin bad++; $display("FAIL single_rnw_rlen: got %b/%0d want 1/7", bus.mem_rnw, bus.mem_rlen); end
    step();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      exp_d          = 32'ha000_0000 + 32'(i);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = exp_d;
      #1;
      total++; if (bus.req_rvalid !== 2'b10) begin bad++; $display("FAIL single_beat%0d_rvalid: got %b want 10", i, bus.req_rvalid); end
      total++; if (bus.req_rdata !== exp_d) begin bad++; $display("FAIL single_beat%0d_rdata: got %h want %h", i, bus.req_rdata, exp_d); end
      step();
    end
    bus.mem_rvalid = 1'b0;
    #1;
    total++; if (dut.resp_empty !== 1'b1) begin bad++; $display("FAIL single_fifo_empty: got %b want 1", dut.resp_empty); end
    step();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_ack;
    logic [29:0] exp_addr;
    logic [31:0] exp_wd;
    set_port(0, 1'b1, 30'h10, 1'b0, 5'd0, 32'h1111_0000);
    set_port(1, 1'b1, 30'h20, 1'b0, 5'd0, 32'h2222_0000);
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 30'h10 : 30'h20;
      exp_wd   = (k % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000;
      #1;
      total++; if (bus.req_ack !== exp_ack) begin bad++; $display("FAIL contention%0d_ack: got %b want %b", k, bus.req_ack, exp_ack); end
      total++; if (bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wd) begin bad++; $display("FAIL contention%0d_fields: got %h/%h want %h/%h", k, bus.mem_addr, bus.mem_wdata, exp_addr, exp_wd); end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_grant_lock();
    set_port(0, 1'b1, 30'h30, 1'b0, 5'd0, 32'h3333_3333);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b01) begin bad++; $display("FAIL lock_pre_ack: got %b want 01", bus.req_ack); end
    step();
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) set_port(1, 1'b1, 30'h40, 1'b0, 5'd0, 32'h4444_4444);
      #1;
      total++; if (bus.mem_addr !== 30'h30 || bus.mem_request !== 1'b1) begin bad++; $display("FAIL lock_hold%0d: got %h/%b want 30/1", c, bus.mem_addr, bus.mem_request); end
      total++; if (bus.req_ack !== 2'b00) begin bad++; $display("FAIL lock_hold%0d_ack: got %b want 00", c, bus.req_ack); end
      step();
    end
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b01 || bus.mem_addr !== 30'h30) begin bad++; $display("FAIL lock_release: got %b/%h want 01/30", bus.req_ack, bus.mem_addr); end
    step();
    bus.req_request[0] = 1'b0;
    #1;
    total++; if (bus.req_ack !== 2'b10 || bus.mem_addr !== 30'h40) begin bad++; $display("FAIL lock_next_grant: got %b/%h want 10/40", bus.req_ack, bus.mem_addr); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_write_outstanding();
    bus.write_outstanding = 1'b1;
    #1;
    total++; if (bus.port_write_outstanding !== 2'b00) begin bad++; $display("FAIL wo_idle: got %b want 00", bus.port_write_outstanding); end
    step();
    set_port(1, 1'b1, 30'h50, 1'b0, 5'd0, 32'h5555_5555);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b10 || bus.port_write_outstanding !== 2'b00) begin bad++; $display("FAIL wo_ack: got %b/%b want 10/00", bus.req_ack, bus.port_write_outstanding); end
    step();
    bus.req_request = '0;
    bus.mem_ack     = 1'b0;
    #1;
    total++; if (bus.port_write_outstanding !== 2'b10) begin bad++; $display("FAIL wo_set: got %b want 10", bus.port_write_outstanding); end
    step();
    bus.write_outstanding = 1'b0;
    #1;
    total++; if (bus.port_write_outstanding !== 2'b00) begin bad++; $display("FAIL wo_gated: got %b want 00", bus.port_write_outstanding); end
    step();
    bus.write_outstanding = 1'b1;
    #1;
    total++; if (bus.port_write_outstanding !== 2'b00) begin bad++; $display("FAIL wo_cleared: got %b want 00", bus.port_write_outstanding); end
    step();
    clear_inputs();
  endtask

  task automatic test_interleaved();
    set_port(0, 1'b1, 30'h60, 1'b1, 5'd3, 32'h0);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b01) begin bad++; $display("FAIL inter_ack0: got %b want 01", bus.req_ack); end
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1;
      #1;
      total++; if (bus.req_rvalid !== 2'b01) begin bad++; $display("FAIL inter_p0_beat%0d: got %b want 01", i, bus.req_rvalid); end
      step();
    end
    bus.mem_rvalid = 1'b1;
    set_port(1, 1'b1, 30'h70, 1'b1, 5'd0, 32'h0);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_rvalid !== 2'b01 || bus.req_ack !== 2'b10) begin bad++; $display("FAIL inter_push_pop: got %b/%b want 01/10", bus.req_rvalid, bus.req_ack); end
    step();
    clear_inputs();
    bus.mem_rvalid = 1'b1;
    #1;
    total++; if (bus.req_rvalid !== 2'b10) begin bad++; $display("FAIL inter_p1_beat: got %b want 10", bus.req_rvalid); end
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    total++; if (dut.resp_empty !== 1'b1) begin bad++; $display("FAIL inter_fifo_empty: got %b want 1", dut.resp_empty); end
    step();
  endtask

  task automatic test_fifo_full();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b1, 30'h80 + 30'(i), 1'b1, 5'd1, 32'h0);
      #1;
      total++; if (bus.req_ack !== 2'b01) begin bad++; $display("FAIL full_fill%0d: got %b want 01", i, bus.req_ack); end
      step();
    end
    set_port(0, 1'b1, 30'h90, 1'b1, 5'd0, 32'h0);
    set_port(1, 1'b1, 30'ha0, 1'b0, 5'd0, 32'haaaa_aaaa);
    #1;
    total++; if (bus.req_ack !== 2'b10 || bus.mem_addr !== 30'ha0) begin bad++; $display("FAIL full_write_bypass: got %b/%h want 10/a0", bus.req_ack, bus.mem_addr); end
    step();
    bus.req_request[1] = 1'b0;
    #1;
    total++; if (bus.mem_request !== 1'b0 || bus.req_ack !== 2'b00) begin bad++; $display("FAIL full_read_stall: got %b/%b want 0/00", bus.mem_request, bus.req_ack); end
    step();
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid = 1'b1;
      #1;
      total++; if (bus.mem_request !== 1'b0 || bus.req_rvalid !== 2'b01) begin bad++; $display("FAIL full_stall_beat%0d: got %b/%b want 0/01", i, bus.mem_request, bus.req_rvalid); end
      step();
    end
    bus.mem_rvalid = 1'b0;
    #1;
    total++; if (bus.req_ack !== 2'b01 || bus.mem_addr !== 30'h90) begin bad++; $display("FAIL full_read_resume: got %b/%h want 01/90", bus.req_ack, bus.mem_addr); end
    step();
    clear_inputs();
    for (int i = 0; i < 7; i++) begin
      bus.mem_rvalid = 1'b1;
      #1;
      total++; if (bus.req_rvalid !== 2'b01) begin bad++; $display("FAIL full_drain%0d: got %b want 01", i, bus.req_rvalid); end
      step();
    end
    bus.mem_rvalid = 1'b0;
    #1;
    total++; if (dut.resp_empty !== 1'b1) begin bad++; $display("FAIL full_fifo_empty: got %b want 1", dut.resp_empty); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    set_port(0, 1'b1, 30'hb0, 1'b1, 5'd7, 32'h0);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b01) begin bad++; $display("FAIL rmb_ack: got %b want 01", bus.req_ack); end
    step();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid = 1'b1;
      #1;
      total++; if (bus.req_rvalid !== 2'b01) begin bad++; $display("FAIL rmb_beat%0d: got %b want 01", i, bus.req_rvalid); end
      step();
    end
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    set_port(0, 1'b1, 30'hc0, 1'b0, 5'd0, 32'h0);
    set_port(1, 1'b1, 30'hd0, 1'b0, 5'd0, 32'h0);
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.mem_request !== 1'b0 || bus.req_ack !== 2'b00 || bus.req_rvalid !== 2'b00) begin bad++; $display("FAIL rmb_in_reset: got %b/%b/%b want 0/00/00", bus.mem_request, bus.req_ack, bus.req_rvalid); end
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    total++; if (bus.mem_request !== 1'b0 || bus.req_ack !== 2'b00 || bus.req_rvalid !== 2'b00) begin bad++; $display("FAIL rmb_after_reset: got %b/%b/%b want 0/00/00", bus.mem_request, bus.req_ack, bus.req_rvalid); end
    total++; if (dut.resp_empty !== 1'b1) begin bad++; $display("FAIL rmb_fifo_empty: got %b want 1", dut.resp_empty); end
    step();
    set_port(0, 1'b1, 30'hc0, 1'b0, 5'd0, 32'h0);
    set_port(1, 1'b1, 30'hd0, 1'b0, 5'd0, 32'h0);
    #1;
    total++; if (bus.mem_addr !== 30'hc0 || bus.mem_request !== 1'b1) begin bad++; $display("FAIL rmb_prio_zero: got %h/%b want c0/1", bus.mem_addr, bus.mem_request); end
    step();
    bus.mem_ack = 1'b1;
    #1;
    total++; if (bus.req_ack !== 2'b01) begin bad++; $display("FAIL rmb_ack_p0: got %b want 01", bus.req_ack); end
    step();
    bus.req_request[0] = 1'b0;
    set_port(1, 1'b1, 30'hd0, 1'b1, 5'd0, 32'h0);
    #1;
    total++; if (bus.req_ack !== 2'b10) begin bad++; $display("FAIL rmb_ack_p1: got %b want 10", bus.req_ack); end
    step();
    clear_inputs();
    bus.mem_rvalid = 1'b1;
    #1;
    total++; if (bus.req_rvalid !== 2'b10) begin bad++; $display("FAIL rmb_new_beat: got %b want 10", bus.req_rvalid); end
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    total++; if (dut.resp_empty !== 1'b1) begin bad++; $display("FAIL rmb_final_empty: got %b want 1", dut.resp_empty); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_grant_lock();
    test_write_outstanding();
    test_interleaved();
    test_fifo_full();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one L1 memory port between N requesters: the instruction cache, the non-invalidating data cache, and optional uncached or debug masters. It applies round-robin arbitration with a grant that holds until the request is accepted. It tracks read bursts in flight so that read-return beats are steered back to the requester that issued them. It sits between the cache controllers and the single external bus port, and replaces ad-hoc point-to-point wiring.

## Interface
- N_PORTS, 2, number of requesters; port 0 has priority after reset.
- RESP_DEPTH, 4, maximum number of read transactions outstanding downstream (power of two, ≥2).
- RLEN_W, 5, burst-length field width; burst length is rlen+1 words.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_request  in  N_PORTS  per-port request, held until acked.
- req_addr  in  N_PORTS×30  word address.
- req_rnw  in  N_PORTS  1 = read.
- req_rlen  in  N_PORTS×RLEN_W  read burst length minus one.
- req_wdata  in  N_PORTS×32  write data.
- req_wbe  in  N_PORTS×4  byte enables.
- req_ack  out  N_PORTS  one-hot; request accepted this cycle.
- req_rvalid  out  N_PORTS  one-hot; read beat for this port.
- req_rdata  out  32  read data, shared across ports.
- mem_request  out  1  downstream request.
- mem_addr, mem_rnw, mem_rlen, mem_wdata, mem_wbe  out  —  muxed fields of the granted port.
- mem_ack  in  1  downstream accepted the request.
- mem_rvalid  in  1  read beat valid; beats return in issue order.
- mem_rdata  in  32  read beat data.
- write_outstanding  in  1  downstream write pending.
- port_write_outstanding  out  N_PORTS  write_outstanding gated to ports that have issued writes since it was last low.

## Operation
- States: IDLE and LOCKED(g).
- Eligibility: a port is eligible if its request is high and either rnw=0 or the response FIFO is not full. A FIFO pop in the same cycle does NOT free space for eligibility.
- IDLE: choose the first eligible port at or after prio_ptr. Drive its fields on mem_* in the same cycle with mem_request=1.
  - If mem_ack, assert req_ack[g] and stay in IDLE.
  - Otherwise go to LOCKED(g).
- LOCKED(g): keep driving port g unconditionally; no other port is granted. On mem_ack, assert req_ack[g] and return to IDLE. The next grant can start in the following cycle.
- Priority: on every ack to port g, prio_ptr becomes (g+1) mod N_PORTS.
- Read accept (ack with rnw=1): push {id=g, rlen} into the response FIFO.
- Read return: the head entry selects req_rvalid[id] = mem_rvalid. beat_cnt increments on each beat. When beat_cnt == head.rlen, pop the head and clear beat_cnt.
  - A push and a pop in the same cycle are both honoured.
  - mem_rvalid with the FIFO empty is an error; assert on it, and drop the beat.
- req_rdata = mem_rdata at all times.
- port_write_outstanding[p]: set on a write ack for p; cleared when write_outstanding is low and no write is acked that cycle; output = flag & write_outstanding.
- Reset values: all req_ack, req_rvalid, mem_request = 0; FIFO empty; beat_cnt = 0; prio_ptr = 0; state IDLE. Reset mid-burst discards in-flight state; the downstream side must reset together.

## Timing
- Grant-to-mem_request latency is 0 cycles (combinational from req_request in IDLE).
- req_ack and req_rvalid are combinational from mem_ack and mem_rvalid respectively; they add no latency.
- Back-to-back grants to different ports are possible in consecutive cycles.
- Simultaneous requests: grant goes to the port nearest prio_ptr; the other port waits at most N_PORTS-1 grants.
- Full FIFO: a read request waits; a write from another port can bypass it.

## Structure
- cva5_types gains typedef mem_arb_resp_t {logic [$clog2(N_PORTS)-1:0] id; logic [RLEN_W-1:0] rlen;}.
- Response tracking uses the existing cva5_fifo sub-module (DATA_TYPE mem_arb_resp_t, FIFO_DEPTH RESP_DEPTH).
- Grant select is a local round-robin priority encoder; it is not a separate module.

## Test plan
- Single read burst: port 1 reads addr 0x100, rlen=7, with ack in the same cycle. Expect req_ack=2'b10 that cycle, then 8 beats on req_rvalid[1] only, then FIFO empty.
- Contention: ports 0 and 1 both request from reset. Expect ack order 0,1,0,1 over four requests per port, and prio_ptr alternating.
- Grant lock: port 0 requests and mem_ack is delayed 3 cycles while port 1 is also requesting. Expect mem_addr to stay on port 0 for 4 cycles, and port 1 to be acked in the next grant.
- Interleaved returns: port 0 reads rlen=3, then port 1 reads rlen=0. Expect 4 beats to port 0 followed by 1 beat to port 1, with the push and pop in the same cycle handled.
- FIFO full: issue 4 reads with no rvalid, then a port 0 read and a port 1 write. Expect the write acked and the read stalled until the first burst completes.
- Reset mid-burst: assert rst after 2 of 8 beats. Expect all outputs at 0, FIFO empty and prio_ptr=0 the next cycle.
